// File: rtl/wgt_loader_if.sv
// wgt_loader_if: DMA weight stream plus weight-SRAM write port.
//   s_tdata/s_tvalid/s_tready/s_tlast : byte-packed input stream, byte 0 in [7:0]
//   we/waddr/wdata/bank_sel_wr       : row write port into the double-buffered SRAM
// master = stream source / buffer side, slave = the loader.
interface wgt_loader_if #(
    parameter int TN         = 14,
    parameter int ADDR_WIDTH = 7,
    parameter int IN_BYTES   = 4
);
    logic [IN_BYTES*8-1:0]  s_tdata;
    logic                   s_tvalid;
    logic                   s_tready;
    logic                   s_tlast;
    logic                   we;
    logic [ADDR_WIDTH-1:0]  waddr;
    logic [TN*8-1:0]        wdata;
    logic                   bank_sel_wr;

    modport master (
        output s_tdata, s_tvalid, s_tlast,
        input  s_tready, we, waddr, wdata, bank_sel_wr
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast,
        output s_tready, we, waddr, wdata, bank_sel_wr
    );
endinterface

// File: rtl/wgt_loader.sv
// wgt_loader: fill stage for the ping-pong weight SRAM.
// Packs IN_BYTES-wide stream beats into TN-byte rows and writes them at
// ascending row addresses into a free bank, then marks that bank full.
// The consumer frees the oldest full bank with bank_release.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, num_rows tile request (num_rows legal 1..2**ADDR_WIDTH)
//   busy, done      tile in progress / one-cycle completion pulse
//   bus             stream in + buffer write port (wgt_loader_if.slave)
//   bank_full       per-bank "complete unread tile" flags
//   rd_bank         bank the consumer reads next
//   bank_release    consumer finished with rd_bank
//   err             sticky [0] illegal num_rows, [1] tlast mismatch
module wgt_loader #(
    parameter int TN         = 14,
    parameter int ADDR_WIDTH = 7,
    parameter int IN_BYTES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_rows,
    output logic                  busy,
    output logic                  done,
    wgt_loader_if.slave           bus,
    output logic [1:0]            bank_full,
    output logic                  rd_bank,
    input  logic                  bank_release,
    output logic [1:0]            err
);
    localparam int CW = (TN > 1) ? $clog2(TN) : 1;
    localparam int RW = TN * 8;
    localparam int XW = (TN + IN_BYTES) * 8;

    localparam logic [CW:0]         TN_C     = TN[CW:0];
    localparam logic [CW:0]         IB_C     = IN_BYTES[CW:0];
    localparam logic [CW-1:0]       TN_L     = TN[CW-1:0];
    localparam logic [CW-1:0]       IB_L     = IN_BYTES[CW-1:0];
    localparam logic [ADDR_WIDTH:0] MAX_ROWS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_BANK, LOAD, FLUSH} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH:0]    rows_tgt;
    logic [ADDR_WIDTH:0]    row_idx;
    logic [CW-1:0]          cnt;        // bytes already in row_buf
    logic [RW-1:0]          row_buf;    // bytes at or above cnt are kept zero
    logic [RW-1:0]          wdata_q;
    logic [ADDR_WIDTH-1:0]  waddr_q;
    logic                   we_q;
    logic                   bank_sel_q;

    logic                   in_load, accept, cfg_ok;
    logic                   row_done, last_row, final_beat, release_ok;
    logic [CW:0]            fill_sum;
    logic [CW-1:0]          left_cnt;
    logic [CW+2:0]          shamt;
    logic [XW-1:0]          merged;
    logic [1:0]             full_set, full_clr;

    assign cfg_ok   = (num_rows != '0) && (num_rows <= MAX_ROWS);
    assign in_load  = (state == LOAD);
    assign accept   = in_load && bus.s_tvalid;

    // Beat bytes land right after the current fill; anything past TN bytes
    // spills into the upper part and seeds the next row.
    assign shamt    = {cnt, 3'b000};
    assign merged   = XW'(row_buf) | (XW'(bus.s_tdata) << shamt);
    assign fill_sum = {1'b0, cnt} + IB_C;
    // Modular in CW bits: the true leftover is < IN_BYTES <= TN, so it fits.
    assign left_cnt = cnt + IB_L - TN_L;
    assign row_done = (fill_sum >= TN_C);
    assign last_row = (row_idx == rows_tgt - 1'b1);
    assign final_beat = accept && row_done && last_row;

    assign release_ok = bank_release && bank_full[rd_bank];
    assign full_set   = (state == FLUSH) ? (2'b01 << bank_sel_q) : 2'b00;
    assign full_clr   = release_ok ? (2'b01 << rd_bank) : 2'b00;

    assign bus.s_tready    = in_load;
    assign bus.we          = we_q;
    assign bus.waddr       = waddr_q;
    assign bus.wdata       = wdata_q;
    assign bus.bank_sel_wr = bank_sel_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_ok) state_nxt = WAIT_BANK;
            end
            WAIT_BANK: begin
                busy = 1'b1;
                if (!bank_full[bank_sel_q]) state_nxt = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (final_beat) state_nxt = FLUSH;
            end
            FLUSH: begin
                // last row's write is on the port this cycle
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_tgt   <= '0;
            row_idx    <= '0;
            cnt        <= '0;
            row_buf    <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            bank_sel_q <= 1'b0;
            bank_full  <= 2'b00;
            rd_bank    <= 1'b0;
            err        <= 2'b00;
        end else begin
            we_q <= 1'b0;

            if (state == IDLE && start) begin
                if (cfg_ok) begin
                    rows_tgt <= num_rows;
                    row_idx  <= '0;
                    cnt      <= '0;
                    row_buf  <= '0;
                end else begin
                    err[0] <= 1'b1;
                end
            end

            if (accept) begin
                // tlast is advisory: loading always runs by count
                if (bus.s_tlast != (row_done && last_row)) err[1] <= 1'b1;
                if (row_done) begin
                    we_q    <= 1'b1;
                    waddr_q <= row_idx[ADDR_WIDTH-1:0];
                    wdata_q <= merged[RW-1:0];
                    row_idx <= row_idx + 1'b1;
                    if (last_row) begin
                        cnt     <= '0;
                        row_buf <= '0;
                    end else begin
                        cnt     <= left_cnt;
                        row_buf <= RW'(merged[XW-1:RW]);
                    end
                end else begin
                    cnt     <= fill_sum[CW-1:0];
                    row_buf <= merged[RW-1:0];
                end
            end

            if (state == FLUSH) bank_sel_q <= ~bank_sel_q;
            // set and clear never target the same bank (WAIT_BANK guards it)
            bank_full <= (bank_full & ~full_clr) | full_set;
            if (release_ok) rd_bank <= ~rd_bank;
        end
    end
endmodule

// File: tb/tb_wgt_loader.sv
module tb_wgt_loader;
    localparam int TN = 14;
    localparam int AW = 7;
    localparam int IB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   num_rows;
    logic          busy, done, rd_bank, bank_release;
    logic [1:0]    bank_full, err;

    wgt_loader_if #(.TN(TN), .ADDR_WIDTH(AW), .IN_BYTES(IB)) bus();

    wgt_loader #(.TN(TN), .ADDR_WIDTH(AW), .IN_BYTES(IB)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .busy(busy), .done(done), .bus(bus), .bank_full(bank_full),
        .rd_bank(rd_bank), .bank_release(bank_release), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            bank;
        logic [AW-1:0]   addr;
        logic [TN*8-1:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] strm[$];
    logic       exp_bank;
    logic       last_bank;
    int         tests = 0;
    int         fails = 0;
    bit         beat_flag = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected row and
    // must be preceded by an accepted beat.
    always @(negedge clk) begin
        if (rst) begin
            beat_flag = 0;
        end else begin
            if (bus.we) begin
                chk("we_after_beat", 128'(beat_flag), 128'(1));
                beat_flag = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_we", 128'(1), 128'(0));
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("waddr", 128'(bus.waddr), 128'(e.addr));
                    chk("wdata", 128'(bus.wdata), 128'(e.data));
                    chk("bank_sel_wr", 128'(bus.bank_sel_wr), 128'(e.bank));
                end
            end
            if (bus.s_tvalid && bus.s_tready) beat_flag = 1;
        end
    end

    function automatic int nbeats(input int n);
        return (n * TN + IB - 1) / IB;
    endfunction

    task automatic gen_stream(input int n, input bit fixed);
        strm.delete();
        for (int i = 0; i < nbeats(n) * IB; i++)
            strm.push_back(fixed ? 8'(i) : 8'($urandom_range(0, 255)));
    endtask

    // Reference: row r is simply stream bytes r*TN .. r*TN+TN-1.
    task automatic push_rows(input int n);
        for (int r = 0; r < n; r++) begin
            wr_t e;
            e.bank = exp_bank;
            e.addr = r[AW-1:0];
            for (int j = 0; j < TN; j++) e.data[j*8 +: 8] = strm[r*TN + j];
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; num_rows = '0; bank_release = 1'b0;
        bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.s_tdata = '0;
        sb.delete();
        exp_bank = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_tready"}, 128'(bus.s_tready), 128'(0));
        chk({tag, "_we"}, 128'(bus.we), 128'(0));
        chk({tag, "_bank_sel"}, 128'(bus.bank_sel_wr), 128'(0));
        chk({tag, "_rd_bank"}, 128'(rd_bank), 128'(0));
        chk({tag, "_bank_full"}, 128'(bank_full), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_waddr"}, 128'(bus.waddr), 128'(0));
        chk({tag, "_wdata"}, 128'(bus.wdata), 128'(0));
    endtask

    task automatic do_start(input int n);
        num_rows = n[AW:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_release();
        bank_release = 1'b1;
        @(posedge clk); #1;
        bank_release = 1'b0;
    endtask

    // gap: 0 = always valid, 1 = toggle every cycle, 2 = random
    task automatic send_beats(input int cnt, input int tl_beat, input int gap);
        int b = 0;
        int cyc = 0;
        bit v;
        while (b < cnt) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            bus.s_tvalid = v;
            for (int i = 0; i < IB; i++) bus.s_tdata[i*8 +: 8] = strm[b*IB + i];
            bus.s_tlast = (b + 1 == tl_beat);
            @(negedge clk);
            if (v && bus.s_tready) b++;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 5000) begin
                chk("beat_timeout", 128'(b), 128'(cnt));
                break;
            end
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_seen", 128'(done), 128'(1));
        last_bank = exp_bank;
        exp_bank  = ~exp_bank;
        @(posedge clk); #1;
        chk("done_pulse", 128'(done), 128'(0));
        chk("busy_after_done", 128'(busy), 128'(0));
    endtask

    task automatic run_tile(input int n, input int gap, input bit fixed, input int tl);
        gen_stream(n, fixed);
        push_rows(n);
        do_start(n);
        send_beats(nbeats(n), (tl == 0) ? nbeats(n) : tl, gap);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state and basic pack
        do_reset();
        chk_zero("reset");
        run_tile(2, 0, 1'b1, 0);
        chk("basic_bank_full", 128'(bank_full), 128'(2'b01));
        chk("basic_err", 128'(err), 128'(0));
        chk("basic_bank_sel", 128'(bus.bank_sel_wr), 128'(1));

        // straddle/discard, then a fresh tile into the other bank
        do_reset();
        run_tile(1, 0, 1'b1, 0);
        run_tile(1, 0, 1'b0, 0);
        chk("straddle_bank_full", 128'(bank_full), 128'(2'b11));

        // ping-pong stall with no release
        do_reset();
        run_tile(2, 2, 1'b0, 0);
        run_tile(3, 0, 1'b0, 0);
        chk("pp_full_both", 128'(bank_full), 128'(2'b11));
        gen_stream(2, 1'b0);
        push_rows(2);
        do_start(2);
        bus.s_tvalid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("pp_stall_tready", 128'(bus.s_tready), 128'(0));
            chk("pp_stall_busy", 128'(busy), 128'(1));
            @(posedge clk); #1;
        end
        bus.s_tvalid = 1'b0;
        do_release();
        chk("pp_release_full", 128'(bank_full), 128'(2'b10));
        chk("pp_release_rd", 128'(rd_bank), 128'(1));
        send_beats(nbeats(2), nbeats(2), 0);
        wait_done();
        chk("pp_tile3_full", 128'(bank_full), 128'(2'b11));
        chk("pp_tile3_bank", 128'(last_bank), 128'(0));

        // gapped valid, then randomized tiles with release in between
        do_reset();
        run_tile(4, 1, 1'b0, 0);
        chk("gap_bank_full", 128'(bank_full), 128'(2'b01));
        for (int t = 0; t < 6; t++) begin
            do_release();
            run_tile((t == 3) ? 128 : int'($urandom_range(1, 9)), int'($urandom_range(0, 2)), 1'b0, 0);
            chk("rand_bank_full", 128'(bank_full), 128'(2'b01 << last_bank));
        end
        chk("rand_err", 128'(err), 128'(0));

        // reset in the middle of a tile
        do_reset();
        gen_stream(2, 1'b0);
        do_start(2);
        send_beats(3, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("midrst");
        repeat (5) @(posedge clk);
        #1;
        run_tile(2, 0, 1'b0, 0);
        chk("midrst_bank_full", 128'(bank_full), 128'(2'b01));

        // error flags
        do_reset();
        do_start(0);
        chk("err_zero_rows", 128'(err), 128'(2'b01));
        chk("err_zero_idle", 128'(busy), 128'(0));
        do_start(129);
        chk("err_big_rows", 128'(err), 128'(2'b01));
        chk("err_big_idle", 128'(busy), 128'(0));
        run_tile(1, 0, 1'b0, 2);
        chk("err_tlast", 128'(err), 128'(2'b11));
        chk("err_tile_full", 128'(bank_full), 128'(2'b01));

        repeat (3) @(posedge clk);
        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
